// File: rtl/evu_pkg.sv
// evu_pkg: shared privilege encodings, e_info field layout and snapshot FSM states for the event counter
package evu_pkg;
  localparam logic [1:0] PRIV_M = 2'b01;
  localparam logic [1:0] PRIV_S = 2'b10;
  localparam logic [1:0] PRIV_U = 2'b11;
  localparam int PRIV_W = 2;
  localparam int ASID_LSB = 0;
  typedef enum logic {IDLE, SEND} snap_state_e;
  function automatic logic priv_ok(logic [2:0] mask, logic [PRIV_W-1:0] priv);
    return priv == PRIV_M ? mask[0] : priv == PRIV_S ? mask[1] : priv == PRIV_U ? mask[2] : 1'b0;
  endfunction
endpackage

// File: rtl/evu_cnt_slice.sv
// evu_cnt_slice: one event counter with clear priority, sticky threshold irq and sticky overflow
module evu_cnt_slice #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 hit_i,
  input  logic                 clr_i,
  input  logic [CNT_WIDTH-1:0] thresh_i,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic [CNT_WIDTH-1:0] cnt_nxt_o,
  output logic                 irq_o,
  output logic                 ovf_o
);
  logic [CNT_WIDTH-1:0] inc;
  always_comb begin
    inc = cnt_o + CNT_WIDTH'(1);
    cnt_nxt_o = clr_i ? '0 : hit_i ? inc : cnt_o;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_o <= '0;
      irq_o <= 1'b0;
      ovf_o <= 1'b0;
    end else begin
      cnt_o <= cnt_nxt_o;
      irq_o <= !clr_i && (irq_o || (hit_i && |thresh_i && inc == thresh_i));
      ovf_o <= !clr_i && (ovf_o || (hit_i && &cnt_o));
    end
  end
endmodule

// File: rtl/evu_event_counter.sv
// evu_event_counter: filters SPU event lines, counts them per line and streams counter snapshots
module evu_event_counter
  import evu_pkg::*;
#(
  parameter int   NUM_EVENTS = 4,
  parameter int   CNT_WIDTH  = 32,
  parameter int   ASID_WIDTH = 16,
  parameter logic SRC_ID     = 1'b0
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NUM_EVENTS-1:0]           e_id_i,
  input  logic [ASID_WIDTH+1:0]           e_info_i,
  input  logic                            s_id_i,
  input  logic [NUM_EVENTS-1:0]           cfg_en_i,
  input  logic [2:0]                      cfg_priv_mask_i,
  input  logic                            cfg_asid_en_i,
  input  logic [ASID_WIDTH-1:0]           cfg_asid_i,
  input  logic [NUM_EVENTS*CNT_WIDTH-1:0] cfg_thresh_i,
  input  logic [NUM_EVENTS-1:0]           clr_i,
  input  logic                            snap_req_i,
  output logic                            snap_busy_o,
  output logic                            snap_valid_o,
  input  logic                            snap_ready_i,
  output logic [$clog2(NUM_EVENTS)-1:0]   snap_idx_o,
  output logic [CNT_WIDTH-1:0]            snap_data_o,
  output logic                            snap_last_o,
  output logic [NUM_EVENTS*CNT_WIDTH-1:0] count_o,
  output logic [NUM_EVENTS-1:0]           irq_o,
  output logic [NUM_EVENTS-1:0]           ovf_o
);
  localparam int IW = $clog2(NUM_EVENTS);
  logic [PRIV_W-1:0] priv;
  logic [ASID_WIDTH-1:0] asid;
  logic [NUM_EVENTS-1:0] hit, hit_q;
  logic [NUM_EVENTS-1:0][CNT_WIDTH-1:0] cnt, cnt_nxt, snap_buf;
  snap_state_e state;
  always_comb begin
    priv = e_info_i[ASID_LSB+ASID_WIDTH +: PRIV_W];
    asid = e_info_i[ASID_LSB +: ASID_WIDTH];
    hit = e_id_i & cfg_en_i & ~clr_i & {NUM_EVENTS{s_id_i == SRC_ID && priv_ok(cfg_priv_mask_i, priv)
          && (!cfg_asid_en_i || asid == cfg_asid_i)}};
  end
  always_ff @(posedge clk_i) hit_q <= rst_i ? '0 : hit;
  for (genvar g = 0; g < NUM_EVENTS; g++) begin : g_slice
    evu_cnt_slice #(.CNT_WIDTH(CNT_WIDTH)) u_slice (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .hit_i    (hit_q[g]),
      .clr_i    (clr_i[g]),
      .thresh_i (cfg_thresh_i[g*CNT_WIDTH +: CNT_WIDTH]),
      .cnt_o    (cnt[g]),
      .cnt_nxt_o(cnt_nxt[g]),
      .irq_o    (irq_o[g]),
      .ovf_o    (ovf_o[g])
    );
  end
  assign count_o = cnt;
  assign snap_data_o = snap_buf[snap_idx_o];
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      snap_buf <= '0;
      snap_idx_o <= '0;
      snap_valid_o <= 1'b0;
      snap_busy_o <= 1'b0;
      snap_last_o <= 1'b0;
    end else if (state == IDLE) begin
      if (snap_req_i) begin
        state <= SEND;
        snap_buf <= cnt_nxt;
        snap_idx_o <= '0;
        snap_valid_o <= 1'b1;
        snap_busy_o <= 1'b1;
        snap_last_o <= NUM_EVENTS == 1;
      end
    end else if (snap_ready_i) begin
      if (snap_last_o) begin
        state <= IDLE;
        snap_valid_o <= 1'b0;
        snap_busy_o <= 1'b0;
        snap_last_o <= 1'b0;
      end else begin
        snap_idx_o <= snap_idx_o + IW'(1);
        snap_last_o <= snap_idx_o + IW'(1) == IW'(NUM_EVENTS - 1);
      end
    end
  end
endmodule
